div_popcount_engine: RTL

- Parametrised successor to the fixed divide-by-10 divider and the combinational 32-bit zero/one counter.
- Contains a runtime-programmable clock divider that produces clk_out, count and an internal tick.
- Contains a sequential popcount engine that consumes LANE_W bits of a latched word per tick, with a start/busy/done handshake.
- Sits between the board clock and the display/statistics logic.

---
 rtl/div_popcount_engine.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/div_popcount_engine.sv
// div_popcount_engine
//   Runtime-programmable clock divider plus a sequential popcount engine.
//   The divider runs freely from clk_in and produces clk_out, count and an
//   internal tick. On each tick the engine consumes LANE_W bits of a word
//   latched on an accepted start. It reports the number of one and zero bits.
//
// Optional feature macro: POPCOUNT_MAXRUN_EN
//   When defined, this adds the output max_run: the longest run of
//   consecutive 1 bits in the latched word.
//
// Ports:
//   clk_in       - sole clock, rising edge
//   reset        - synchronous, active-high reset
//   start        - request a new count (accepted only while busy=0)
//   binary_input - word latched on an accepted start
//   div_ratio    - divisor N (0 treated as 1), sampled every cycle
//   busy         - engine running
//   done         - one-cycle pulse, results valid
//   count_ones   - number of 1 bits in the latched word
//   count_zeros  - number of 0 bits in the latched word
//   max_run      - longest run of 1s (only with POPCOUNT_MAXRUN_EN)
//   clk_out      - registered divided clock
//   count        - divider counter value
module div_popcount_engine #(
  parameter int DATA_W = 32,
  parameter int LANE_W = 4,
  parameter int DIV_W  = 4,
  localparam int CW    = $clog2(DATA_W + 1)
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] binary_input,
  input  logic [DIV_W-1:0]  div_ratio,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     count_ones,
  output logic [CW-1:0]     count_zeros,
`ifdef POPCOUNT_MAXRUN_EN
  output logic [CW-1:0]     max_run,
`endif
  output logic              clk_out,
  output logic [DIV_W-1:0]  count
);

  localparam int STEPS = DATA_W / LANE_W;
  localparam int SW    = $clog2(STEPS + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [SW-1:0]      step_q, step_d;
  logic [CW-1:0]      ones_d, zeros_d, lane_ones;
  logic               done_d;

  // ---------------- divider ----------------
  logic [DIV_W-1:0] neff;
  logic [DIV_W:0]   half;
  logic             tick;
  logic [DIV_W-1:0] count_nxt;

  always_comb begin
    neff      = (div_ratio == '0) ? DIV_W'(1) : div_ratio;
    half      = ({1'b0, neff} + (DIV_W+1)'(1)) >> 1;   // ceil(Neff/2)
    // >= rather than == so that lowering div_ratio mid-period wraps at once
    tick      = (count >= neff - DIV_W'(1));
    count_nxt = tick ? '0 : count + DIV_W'(1);
  end

  // clk_out is computed from the next count so it matches count after the edge
  always_ff @(posedge clk_in) begin
    if (reset) begin
      count   <= '0;
      clk_out <= 1'b1;
    end else begin
      count   <= count_nxt;
      clk_out <= ({1'b0, count_nxt} < half);
    end
  end

  // ---------------- popcount engine ----------------
  logic load, step_en;

  assign load    = (state_q == IDLE) && start;
  assign step_en = (state_q == RUN) && tick;
  assign busy    = (state_q == RUN);

  always_comb begin
    lane_ones = '0;
    for (int unsigned i = 0; i < LANE_W; i++)
      lane_ones = lane_ones + CW'(shift_q[i]);
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    step_d  = step_q;
    ones_d  = count_ones;
    zeros_d = count_zeros;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = binary_input;
          step_d  = '0;
          ones_d  = '0;
          zeros_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (tick) begin
          ones_d  = count_ones + lane_ones;
          zeros_d = count_zeros + (CW'(LANE_W) - lane_ones);
          shift_d = shift_q >> LANE_W;
          step_d  = step_q + SW'(1);
          if (step_q == SW'(STEPS - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      step_q      <= '0;
      count_ones  <= '0;
      count_zeros <= '0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      step_q      <= step_d;
      count_ones  <= ones_d;
      count_zeros <= zeros_d;
      done        <= done_d;
    end
  end

`ifdef POPCOUNT_MAXRUN_EN
  // The run length carries across lanes, so bits are scanned LSB first.
  logic [CW-1:0] run_q, run_d, max_d;

  always_comb begin
    run_d = run_q;
    max_d = max_run;
    if (load) begin
      run_d = '0;
      max_d = '0;
    end else if (step_en) begin
      for (int unsigned i = 0; i < LANE_W; i++) begin
        if (shift_q[i]) begin
          run_d = run_d + CW'(1);
          if (run_d > max_d) max_d = run_d;
        end else begin
          run_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      run_q   <= '0;
      max_run <= '0;
    end else begin
      run_q   <= run_d;
      max_run <= max_d;
    end
  end
`endif

endmodule
